// File: rtl/dma_axil_mem_responder.sv
// SRAM-backed AXI-lite-style target for DMA write/read requests with programmable
// wait states, round-robin write/read arbitration and out-of-range error reporting.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no transfer in flight; arbitrates and accepts requests
// WR_WAIT | write accepted, counting wait states
// RD_WAIT | read accepted, counting wait states
// WR_ACK  | one-cycle wready pulse; byte-enabled commit to memory
// RD_ACK  | one-cycle rvalid pulse; rdata presented
module dma_axil_mem_responder #(
   parameter int              ADDR_WIDTH = 16,
   parameter int              DATA_WIDTH = 64,
   parameter int              STRB_WIDTH = DATA_WIDTH/8,
   parameter int              DEPTH      = 256,
   parameter longint unsigned BASE_ADDR  = 0,
   parameter int              WR_LAT     = 1,
   parameter int              RD_LAT     = 2
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  aenable,
   input  logic                  i_axil_wvalid,
   input  logic [STRB_WIDTH-1:0] i_axil_wstrb,
   input  logic [DATA_WIDTH-1:0] i_axil_wdata,
   input  logic [ADDR_WIDTH-1:0] i_axil_waddr,
   output logic                  o_axil_wready,
   input  logic                  i_axil_rready,
   input  logic [ADDR_WIDTH-1:0] i_axil_raddr,
   output logic                  o_axil_rvalid,
   output logic [DATA_WIDTH-1:0] o_axil_rdata,
   output logic                  o_addr_err
);

   localparam int WORD_SHIFT = $clog2(STRB_WIDTH);
   localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int MAX_LAT    = (WR_LAT > RD_LAT) ? WR_LAT : RD_LAT;
   localparam int CNT_W      = (MAX_LAT > 2) ? $clog2(MAX_LAT - 1) : 1;

   localparam logic [63:0] ADDR_LO   = 64'(BASE_ADDR);
   localparam logic [63:0] MEM_BYTES = 64'(DEPTH) * 64'(STRB_WIDTH);

   // WAIT holds for LAT-1 cycles, so the counter starts at LAT-2 and ACK follows terminal count
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'((WR_LAT >= 2) ? WR_LAT - 2 : 0);
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'((RD_LAT >= 2) ? RD_LAT - 2 : 0);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_WAIT = 3'd1,
      RD_WAIT = 3'd2,
      WR_ACK  = 3'd3,
      RD_ACK  = 3'd4
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             prio_rd;
   logic             prio_rd_nxt;

   logic                  grant_wr;
   logic                  grant_rd;
   logic                  accept_wr;
   logic                  accept_rd;
   logic [ADDR_WIDTH-1:0] acc_addr;
   logic [63:0]           acc_off;
   logic                  acc_err;
   logic [IDX_W-1:0]      acc_idx;

   logic [IDX_W-1:0]      idx_q;
   logic                  err_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_WIDTH-1:0] wstrb_q;
   logic [IDX_W-1:0]      rd_idx;
   logic                  rd_err;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Below-base addresses wrap to a huge offset, so one compare covers both range limits
   always_comb begin
      grant_wr  = i_axil_wvalid && (!i_axil_rready || !prio_rd);
      grant_rd  = i_axil_rready && (!i_axil_wvalid || prio_rd);
      accept_wr = (state == IDLE) && aenable && grant_wr;
      accept_rd = (state == IDLE) && aenable && grant_rd;
      acc_addr  = grant_wr ? i_axil_waddr : i_axil_raddr;
      acc_off   = 64'(acc_addr) - ADDR_LO;
      acc_err   = (acc_off >= MEM_BYTES);
      acc_idx   = IDX_W'(acc_off >> WORD_SHIFT);
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      prio_rd_nxt = prio_rd;
      case (state)
         IDLE: begin
            if (accept_wr) begin
               state_nxt = (WR_LAT == 1) ? WR_ACK : WR_WAIT;
               cnt_nxt   = WR_LOAD;
            end else if (accept_rd) begin
               state_nxt = (RD_LAT == 1) ? RD_ACK : RD_WAIT;
               cnt_nxt   = RD_LOAD;
            end
         end
         WR_WAIT: begin
            if (!i_axil_wvalid) begin
               state_nxt = IDLE;
            end else if (cnt == '0) begin
               state_nxt = WR_ACK;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         RD_WAIT: begin
            if (!i_axil_rready) begin
               state_nxt = IDLE;
            end else if (cnt == '0) begin
               state_nxt = RD_ACK;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         WR_ACK: begin
            state_nxt   = IDLE;
            prio_rd_nxt = 1'b1;
         end
         RD_ACK: begin
            state_nxt   = IDLE;
            prio_rd_nxt = 1'b0;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state   <= IDLE;
         cnt     <= '0;
         prio_rd <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         prio_rd <= prio_rd_nxt;
      end
   end

   // With RD_LAT==1 the ACK is entered straight from IDLE, before idx_q/err_q are loaded
   always_comb begin
      rd_idx = (state == IDLE) ? acc_idx : idx_q;
      rd_err = (state == IDLE) ? acc_err : err_q;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         idx_q        <= '0;
         err_q        <= 1'b0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         o_axil_rdata <= '0;
      end else begin
         if (accept_wr || accept_rd) begin
            idx_q <= acc_idx;
            err_q <= acc_err;
         end
         if (accept_wr) begin
            wdata_q <= i_axil_wdata;
            wstrb_q <= i_axil_wstrb;
         end
         if (state_nxt == RD_ACK) begin
            o_axil_rdata <= rd_err ? '0 : mem[rd_idx];
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (!areset && (state == WR_ACK) && !err_q) begin
         for (int b = 0; b < STRB_WIDTH; b++) begin
            if (wstrb_q[b]) begin
               mem[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
         end
      end
   end

   assign o_axil_wready = (state == WR_ACK);
   assign o_axil_rvalid = (state == RD_ACK);
   assign o_addr_err    = err_q && ((state == WR_ACK) || (state == RD_ACK));

endmodule

// File: tb/tb_dma_axil_mem_responder.sv
// Directed bench for dma_axil_mem_responder: default latencies on one instance,
// WR_LAT=RD_LAT=3 on a second for abort and mid-transfer reset.
module tb_dma_axil_mem_responder;

   logic        aclk = 1'b0;
   logic        areset, aenable;
   logic        wvalid, rready;
   logic [7:0]  wstrb;
   logic [63:0] wdata;
   logic [15:0] waddr, raddr;
   logic        wready, rvalid, addr_err;
   logic [63:0] rdata;

   logic        b_areset, b_aenable;
   logic        b_wvalid, b_rready;
   logic [7:0]  b_wstrb;
   logic [63:0] b_wdata;
   logic [15:0] b_waddr, b_raddr;
   logic        b_wready, b_rvalid, b_addr_err;
   logic [63:0] b_rdata;

   int n_vec = 0;
   int n_err = 0;

   always #5 aclk = ~aclk;

   dma_axil_mem_responder u_dut (
      .aclk          (aclk),
      .areset        (areset),
      .aenable       (aenable),
      .i_axil_wvalid (wvalid),
      .i_axil_wstrb  (wstrb),
      .i_axil_wdata  (wdata),
      .i_axil_waddr  (waddr),
      .o_axil_wready (wready),
      .i_axil_rready (rready),
      .i_axil_raddr  (raddr),
      .o_axil_rvalid (rvalid),
      .o_axil_rdata  (rdata),
      .o_addr_err    (addr_err)
   );

   dma_axil_mem_responder #(.WR_LAT(3), .RD_LAT(3)) u_dut_lat3 (
      .aclk          (aclk),
      .areset        (b_areset),
      .aenable       (b_aenable),
      .i_axil_wvalid (b_wvalid),
      .i_axil_wstrb  (b_wstrb),
      .i_axil_wdata  (b_wdata),
      .i_axil_waddr  (b_waddr),
      .o_axil_wready (b_wready),
      .i_axil_rready (b_rready),
      .i_axil_raddr  (b_raddr),
      .o_axil_rvalid (b_rvalid),
      .o_axil_rdata  (b_rdata),
      .o_addr_err    (b_addr_err)
   );

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   initial begin
      areset = 1'b1; aenable = 1'b1; wvalid = 1'b0; rready = 1'b0;
      wstrb = '0; wdata = '0; waddr = '0; raddr = '0;
      b_areset = 1'b1; b_aenable = 1'b1; b_wvalid = 1'b0; b_rready = 1'b0;
      b_wstrb = '0; b_wdata = '0; b_waddr = '0; b_raddr = '0;
      step(); step(); step();
      chk("rst_wready", wready, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_err", addr_err, 0);
      chk("rst_b_wready", b_wready, 0);
      areset = 1'b0; b_areset = 1'b0;

      // full-strobe write, read back at latency 2
      wvalid = 1; waddr = 16'h0010; wdata = 64'h1122334455667788; wstrb = 8'hFF;
      step(); chk("wr1_wready", wready, 1); chk("wr1_err", addr_err, 0); wvalid = 0;
      step(); chk("wr1_pulse", wready, 0);
      step(); step(); step();
      rready = 1; raddr = 16'h0010;
      step(); chk("rd1_early", rvalid, 0);
      step(); chk("rd1_rvalid", rvalid, 1); chk("rd1_rdata", rdata, 64'h1122334455667788); rready = 0;
      step(); chk("rd1_pulse", rvalid, 0); chk("rd1_hold", rdata, 64'h1122334455667788);

      // partial strobe, then all-zero strobe
      wvalid = 1; wdata = 64'hAAAAAAAAAAAAAAAA; wstrb = 8'h0F;
      step(); chk("wr2_wready", wready, 1); wvalid = 0;
      step(); rready = 1;
      step(); step(); chk("rd2_rvalid", rvalid, 1); chk("rd2_rdata", rdata, 64'h11223344AAAAAAAA); rready = 0;
      step();
      wvalid = 1; wdata = 64'h0; wstrb = 8'h00;
      step(); chk("wr3_wready", wready, 1); wvalid = 0;
      step(); rready = 1;
      step(); step(); chk("rd3_rdata", rdata, 64'h11223344AAAAAAAA); rready = 0;
      step();

      // round robin: priority back to write after reset
      areset = 1; step(); areset = 0;
      chk("rst2_rdata", rdata, 0);
      wvalid = 1; waddr = 16'h0020; wdata = 64'h0123456789ABCDEF; wstrb = 8'hFF;
      rready = 1; raddr = 16'h0010;
      step(); chk("rr_wr_first", wready, 1); chk("rr_c1_rvalid", rvalid, 0);
      step(); chk("rr_c2_wready", wready, 0); chk("rr_c2_rvalid", rvalid, 0);
      step(); chk("rr_c3_rvalid", rvalid, 0); chk("rr_c3_wready", wready, 0);
      step(); chk("rr_rd_second", rvalid, 1); chk("rr_rd_data", rdata, 64'h11223344AAAAAAAA);
      raddr = 16'h0020;
      step(); chk("rr_c5_wready", wready, 0);
      step(); chk("rr_wr_third", wready, 1); chk("rr_c6_rvalid", rvalid, 0);
      step(); chk("rr_c7_rvalid", rvalid, 0);
      step();
      step(); chk("rr_rd_fourth", rvalid, 1); chk("rr_rd4_data", rdata, 64'h0123456789ABCDEF);
      wvalid = 0; rready = 0;
      step();

      // out of range: first byte past the array, and the last in-range word
      wvalid = 1; waddr = 16'h0000; wdata = 64'h5555555555555555; wstrb = 8'hFF;
      step(); chk("w0_wready", wready, 1); wvalid = 0;
      step();
      wvalid = 1; waddr = 16'h0800; wdata = 64'hDEADBEEFDEADBEEF;
      step(); chk("oor_w_wready", wready, 1); chk("oor_w_err", addr_err, 1); wvalid = 0;
      step(); chk("oor_w_err_pulse", addr_err, 0);
      rready = 1; raddr = 16'h0000;
      step(); step(); chk("w0_rvalid", rvalid, 1); chk("w0_unchanged", rdata, 64'h5555555555555555); rready = 0;
      step();
      rready = 1; raddr = 16'h0800;
      step(); chk("oor_r_early", rvalid, 0); chk("oor_r_err_early", addr_err, 0);
      step(); chk("oor_r_rvalid", rvalid, 1); chk("oor_r_rdata", rdata, 0); chk("oor_r_err", addr_err, 1);
      rready = 0;
      step();
      wvalid = 1; waddr = 16'h07F8; wdata = 64'h0102030405060708;
      step(); chk("last_w_wready", wready, 1); chk("last_w_err", addr_err, 0); wvalid = 0;
      step();
      rready = 1; raddr = 16'h07FD;
      step(); step(); chk("last_r_rvalid", rvalid, 1); chk("last_r_rdata", rdata, 64'h0102030405060708);
      chk("last_r_err", addr_err, 0); rready = 0;
      step();

      // enable gating: held request waits, in-flight read survives disable
      aenable = 0; wvalid = 1; waddr = 16'h0030; wdata = 64'hCAFEF00D12345678;
      for (int i = 1; i <= 5; i++) begin
         step(); chk($sformatf("en_off_c%0d", i), wready, 0);
      end
      aenable = 1;
      step(); chk("en_on_wready", wready, 1); wvalid = 0;
      step();
      rready = 1; raddr = 16'h0030;
      step(); aenable = 0;
      step(); chk("inflight_rvalid", rvalid, 1); chk("inflight_rdata", rdata, 64'hCAFEF00D12345678);
      rready = 0; aenable = 1;
      step();

      // latency-3 instance: write, read abort, new read, reset mid-write
      b_wvalid = 1; b_waddr = 16'h0010; b_wdata = 64'h0F0E0D0C0B0A0908; b_wstrb = 8'hFF;
      step(); chk("b_wr_c1", b_wready, 0);
      step(); chk("b_wr_c2", b_wready, 0);
      step(); chk("b_wr_c3", b_wready, 1); b_wvalid = 0;
      step();
      b_rready = 1; b_raddr = 16'h0010;
      step(); b_rready = 0;
      step(); chk("b_abort_c2", b_rvalid, 0); b_rready = 1;
      step(); chk("b_abort_c3", b_rvalid, 0);
      step(); chk("b_rd2_c4", b_rvalid, 0);
      step(); chk("b_rd2_rvalid", b_rvalid, 1); chk("b_rd2_rdata", b_rdata, 64'h0F0E0D0C0B0A0908);
      b_rready = 0;
      step();
      b_wvalid = 1; b_wdata = 64'hFFFFFFFFFFFFFFFF;
      step(); step(); b_areset = 1;
      step();
      chk("b_rst_wready", b_wready, 0); chk("b_rst_rvalid", b_rvalid, 0);
      chk("b_rst_err", b_addr_err, 0); chk("b_rst_rdata", b_rdata, 0);
      b_areset = 0; b_wvalid = 0;
      step();
      b_rready = 1;
      step(); step(); step();
      chk("b_rd3_rvalid", b_rvalid, 1); chk("b_rd3_unchanged", b_rdata, 64'h0F0E0D0C0B0A0908);
      b_rready = 0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
